mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameters: ADDR_W, default 12, RAM word-address width; DATA_W, default 32, RAM data width; INIT_EN, default 1, zero-fill the RAM after reset when 1.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset, with ports as follows.
- clock  in  1  sole clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- reqN_valid  in  1  request from requester N (N=0,1).
- reqN_ready  out  1  request accepted when valid&ready.
- reqN_write  in  1  1=write, 0=read.
- reqN_addr  in  ADDR_W  word address.
- reqN_wdata  in  DATA_W  write data.
- reqN_mask  in  DATA_W/8  byte write enables.
- respN_valid  out  1  response available.
- respN_ready  in  1  response consumed when valid&ready.
- respN_rdata  out  DATA_W  read data; 0 for writes.
- ram_en  out  1  to single-port RAM enable.
- ram_wmode  out  1  RAM write mode.
- ram_addr  out  ADDR_W  RAM address.
- ram_wmask  out  DATA_W/8  RAM byte mask.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data, valid the cycle after a read enable.
- init_done  out  1  high once zero-fill is complete.

Function
REQ-003 The block SHALL have FSM states INIT and RUN; it SHALL enter INIT on reset when INIT_EN=1 and RUN directly when INIT_EN=0.
REQ-004 In INIT the block SHALL drive ram_en=1, ram_wmode=1, ram_wmask=all ones, ram_wdata=0, ram_addr=init counter, and increment the counter by 1 per cycle from 0.
REQ-005 The block SHALL leave INIT for RUN after the cycle writing address 2^ADDR_W-1, and init_done SHALL rise in the first RUN cycle and stay high until reset.
REQ-006 In INIT both reqN_ready SHALL be 0.
REQ-007 The block SHALL mark requester N eligible in RUN when reqN_valid=1 and busyN=0, where busyN = inflightN | respN_valid.
REQ-008 The block SHALL grant at most one requester per cycle; if both are eligible, it SHALL grant the one indicated by a round-robin pointer (reset value 0).
REQ-009 After each grant, the block SHALL set the pointer to the non-granted requester; with no grant, the pointer SHALL hold.
REQ-010 reqN_ready SHALL equal grantN, combinational in the same cycle, and SHALL NOT depend on respN_ready.
REQ-011 In a grant cycle the block SHALL drive the RAM combinationally from the granted request: ram_en=1, ram_wmode=reqN_write, ram_addr, ram_wmask, ram_wdata.
REQ-012 In RUN cycles with no grant, ram_en SHALL be 0.
REQ-013 On acceptance at cycle T, the block SHALL set inflightN for cycle T+1, together with a registered owner ID and an is_read flag.
REQ-014 At the end of T+1, the block SHALL load respN_rdata with ram_rdata (read) or 0 (write), set respN_valid, and clear inflightN; respN_valid is therefore high from cycle T+2.
REQ-015 respN_valid and respN_rdata SHALL hold stable until respN_ready=1, then clear respN_valid on that edge; requester N becomes eligible again the cycle after.
REQ-016 Each requester SHALL have at most one outstanding transaction; responses per requester SHALL return in request order.
REQ-017 Backpressure on resp0 SHALL NOT stall requester 1, and vice versa.
REQ-018 A read to an address written in the immediately preceding cycle SHALL return the new data, because the RAM write completes before the read edge.
REQ-019 The block SHALL compute ram_wmask width as DATA_W/8; DATA_W SHALL be a multiple of 8.

Reset
REQ-020 Reset assertion SHALL immediately force the following: FSM=INIT (or RUN if INIT_EN=0), init counter=0, pointer=0, inflightN=0, respN_valid=0, respN_rdata=0, init_done=0, reqN_ready=0, ram_en=0.
REQ-021 Reset asserted mid-INIT SHALL restart zero-fill from address 0; reset mid-transaction SHALL drop in-flight and buffered responses without emitting them.
REQ-022 Reset deassertion SHALL be synchronised externally; the block SHALL start in INIT on the first clock edge after deassertion.

Verification
REQ-023 Release reset with ADDR_W=4 -> ram_en=1, wmode=1, addr 0..15 over 16 cycles, init_done=1 on cycle 17; read of addr 7 returns 0x00000000.
REQ-024 Req0 write addr 0x005, data 0xDEADBEEF, mask 0xF, then read 0x005 -> resp0 with rdata 0, then resp0 rdata 0xDEADBEEF, each exactly 2 cycles after its acceptance.
REQ-025 Write addr 0x010 = 0x11223344 with mask 0x5 over a zeroed word, then read -> rdata 0x00220044.
REQ-026 Both requesters valid continuously with resp ready=1 -> grants alternate 0,1,0,1; neither starves; each requester achieves 1 acceptance per 3 cycles.
REQ-027 Hold resp0_ready=0 for 10 cycles -> resp0 data stable, req0_ready=0, req1 continues to be served; releasing resp0_ready lets req0 be accepted on the following cycle.
REQ-028 Assert reset while req1 read is in flight and again at init counter 0x800 -> no resp1_valid after release; zero-fill restarts at address 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Two-requester round-robin front end for a single-port RAM.
//            After reset it can zero-fill the RAM. Each requester may have
//            one transaction outstanding. Its response is buffered until
//            the requester consumes it.
// Ports    : clock_i/reset_i        - clock, async active-high reset
//            reqN_*_i / reqN_ready_o - request channel, N = 0,1
//            respN_*               - response channel, N = 0,1
//            ram_*                 - single-port RAM (read data one cycle late)
//            init_done_o           - zero-fill complete
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter bit INIT_EN = 1'b1
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic                req0_valid_i,
  output logic                req0_ready_o,
  input  logic                req0_write_i,
  input  logic [ADDR_W-1:0]   req0_addr_i,
  input  logic [DATA_W-1:0]   req0_wdata_i,
  input  logic [DATA_W/8-1:0] req0_mask_i,
  output logic                resp0_valid_o,
  input  logic                resp0_ready_i,
  output logic [DATA_W-1:0]   resp0_rdata_o,
  input  logic                req1_valid_i,
  output logic                req1_ready_o,
  input  logic                req1_write_i,
  input  logic [ADDR_W-1:0]   req1_addr_i,
  input  logic [DATA_W-1:0]   req1_wdata_i,
  input  logic [DATA_W/8-1:0] req1_mask_i,
  output logic                resp1_valid_o,
  input  logic                resp1_ready_i,
  output logic [DATA_W-1:0]   resp1_rdata_o,
  output logic                ram_en_o,
  output logic                ram_wmode_o,
  output logic [ADDR_W-1:0]   ram_addr_o,
  output logic [DATA_W/8-1:0] ram_wmask_o,
  output logic [DATA_W-1:0]   ram_wdata_o,
  input  logic [DATA_W-1:0]   ram_rdata_i,
  output logic                init_done_o
);

  localparam int MASK_W = DATA_W / 8;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam state_t RESET_STATE = INIT_EN ? ST_INIT : ST_RUN;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                ptr_q, ptr_d;
  logic                inflight_q, inflight_d;
  logic                owner_q, owner_d;
  logic                is_read_q, is_read_d;
  logic [1:0]          resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d;
  logic [DATA_W-1:0]   rdata1_q, rdata1_d;
  logic                init_done_q, init_done_d;

  logic busy0, busy1, elig0, elig1, gnt0, gnt1;

  // Only one grant per cycle, so a single in-flight slot tagged with its
  // owner represents both per-requester in-flight flags.
  assign busy0 = (inflight_q & ~owner_q) | resp_valid_q[0];
  assign busy1 = (inflight_q &  owner_q) | resp_valid_q[1];

  // Reset is folded into the grants so the ready outputs drop the moment
  // reset is asserted, not at the next edge.
  assign elig0 = (state_q == ST_RUN) & ~reset_i & req0_valid_i & ~busy0;
  assign elig1 = (state_q == ST_RUN) & ~reset_i & req1_valid_i & ~busy1;
  assign gnt0  = elig0 & (~elig1 | ~ptr_q);
  assign gnt1  = elig1 & (~elig0 |  ptr_q);

  assign req0_ready_o  = gnt0;
  assign req1_ready_o  = gnt1;
  assign resp0_valid_o = resp_valid_q[0];
  assign resp1_valid_o = resp_valid_q[1];
  assign resp0_rdata_o = rdata0_q;
  assign resp1_rdata_o = rdata1_q;
  assign init_done_o   = init_done_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ptr_d        = ptr_q;
    inflight_d   = gnt0 | gnt1;
    owner_d      = owner_q;
    is_read_d    = is_read_q;
    resp_valid_d = resp_valid_q & ~{resp1_ready_i, resp0_ready_i};
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    ram_en_o     = 1'b0;
    ram_wmode_o  = 1'b0;
    ram_addr_o   = '0;
    ram_wmask_o  = '0;
    ram_wdata_o  = '0;

    case (state_q)
      ST_INIT: begin
        ram_en_o    = 1'b1;
        ram_wmode_o = 1'b1;
        ram_wmask_o = {MASK_W{1'b1}};
        ram_addr_o  = cnt_q;
        cnt_d       = cnt_q + 1'b1;
        if (cnt_q == {ADDR_W{1'b1}}) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        if (gnt0) begin
          ram_en_o    = 1'b1;
          ram_wmode_o = req0_write_i;
          ram_addr_o  = req0_addr_i;
          ram_wmask_o = req0_mask_i;
          ram_wdata_o = req0_wdata_i;
          ptr_d       = 1'b1;
          owner_d     = 1'b0;
          is_read_d   = ~req0_write_i;
        end else if (gnt1) begin
          ram_en_o    = 1'b1;
          ram_wmode_o = req1_write_i;
          ram_addr_o  = req1_addr_i;
          ram_wmask_o = req1_mask_i;
          ram_wdata_o = req1_wdata_i;
          ptr_d       = 1'b0;
          owner_d     = 1'b1;
          is_read_d   = ~req1_write_i;
        end
      end
    endcase

    // RAM read data is valid in the cycle after the access; capture it into
    // the owner's response buffer. Owner cannot be holding a response here.
    if (inflight_q) begin
      if (owner_q) begin
        resp_valid_d[1] = 1'b1;
        rdata1_d        = is_read_q ? ram_rdata_i : '0;
      end else begin
        resp_valid_d[0] = 1'b1;
        rdata0_d        = is_read_q ? ram_rdata_i : '0;
      end
    end

    if (reset_i) begin
      ram_en_o = 1'b0;
    end

    init_done_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= RESET_STATE;
      cnt_q        <= '0;
      ptr_q        <= 1'b0;
      inflight_q   <= 1'b0;
      owner_q      <= 1'b0;
      is_read_q    <= 1'b0;
      resp_valid_q <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      init_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ptr_q        <= ptr_d;
      inflight_q   <= inflight_d;
      owner_q      <= owner_d;
      is_read_q    <= is_read_d;
      resp_valid_q <= resp_valid_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      init_done_q  <= init_done_d;
    end
  end

endmodule
`default_nettype wire
